// File: rtl/pipe_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pipe_adder
//  Purpose  : Parametrised pipelined ripple-carry adder/subtractor with a
//             valid/ready handshake on both sides. WIDTH-bit operands are
//             processed CHUNK bits per stage; the carry is registered
//             between stages.
//  Options  : define PIPE_ADDER_SAT_EN to add the 'sat' input, which clamps
//             the result to the signed extreme on two's-complement overflow.
//  Revision : 1.0  initial release
// ============================================================================
//
//  Pipeline organisation (RANKS = STAGES + 1 register ranks):
//    rank 0        : operand capture (A, B_eff = sub ? ~B : B, carry0, sat)
//    rank k (1..S) : adds slice k-1 of the captured operands
//  An op accepted at edge N therefore presents out_valid after edge N+STAGES.
//
//  Skew/de-skew: the operand registers rotate right by CHUNK every stage,
//  so the next slice to add always sits in bits [CHUNK-1:0] and the upper
//  (unprocessed) slices travel behind it. After STAGES rotations the
//  operands are back in their original alignment, which puts A[MSB] and
//  B_eff[MSB] in place for the overflow flag. Each partial sum is inserted
//  at the top of the result register, which shifts right every stage, so
//  slice 0 lands at bit 0 when the op leaves the last stage.
//
//  WIDTH must be an integer multiple of CHUNK.
// ============================================================================
module pipe_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
`ifdef PIPE_ADDER_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int RANKS  = STAGES + 1;

`ifdef PIPE_ADDER_SAT_EN
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] SAT_POS = ~SAT_NEG;
`endif

   // Per-rank state. Index RANKS-1 is the output rank.
   logic [RANKS-1:0] vld_q, vld_d;          // slot holds a live op
   logic [RANKS-1:0] cy_q,  cy_d;           // carry into next slice / final cout
   logic [WIDTH-1:0] opa_q [RANKS];         // operand A, rotated per stage
   logic [WIDTH-1:0] opa_d [RANKS];
   logic [WIDTH-1:0] opb_q [RANKS];         // effective operand B, rotated per stage
   logic [WIDTH-1:0] opb_d [RANKS];
   logic [WIDTH-1:0] res_q [RANKS];         // partial sums, filled from the top
   logic [WIDTH-1:0] res_d [RANKS];
`ifdef PIPE_ADDER_SAT_EN
   logic [RANKS-1:0] sat_q, sat_d;          // saturate request travelling with op
`endif

   logic             adv;                   // whole pipe shifts this cycle
   logic [WIDTH-1:0] b_eff;
   logic             carry0;
   logic [CHUNK:0]   slice_sum;
   logic             a_msb;
   logic             b_msb;

   // Shift v right by one slice and place s in the vacated top slice.
   function automatic logic [WIDTH-1:0] rot_in(input logic [WIDTH-1:0] v,
                                               input logic [CHUNK-1:0] s);
      logic [WIDTH-1:0] t;
      t            = '0;
      t[CHUNK-1:0] = s;
      return (v >> CHUNK) | (t << (WIDTH - CHUNK));
   endfunction

   // Next-state for every rank: hold when the output is stalled, else shift one rank.
   always_comb begin
      adv       = !vld_q[RANKS-1] || out_ready;
      b_eff     = sub ? ~b : b;
      carry0    = sub ? 1'b1 : ci;
      slice_sum = '0;
      vld_d     = vld_q;
      cy_d      = cy_q;
`ifdef PIPE_ADDER_SAT_EN
      sat_d     = sat_q;
`endif
      for (int k = 0; k < RANKS; k++) begin
         opa_d[k] = opa_q[k];
         opb_d[k] = opb_q[k];
         res_d[k] = res_q[k];
      end

      if (adv) begin
         // Capture rank: bubbles are shifted in as valid=0 slots.
         vld_d[0] = in_valid;
         opa_d[0] = a;
         opb_d[0] = b_eff;
         res_d[0] = '0;
         cy_d[0]  = carry0;
`ifdef PIPE_ADDER_SAT_EN
         sat_d[0] = sat;
`endif
         // Adder ranks: each consumes the low slice of the previous rank.
         for (int k = 1; k < RANKS; k++) begin
            slice_sum = {1'b0, opa_q[k-1][CHUNK-1:0]}
                      + {1'b0, opb_q[k-1][CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, cy_q[k-1]};
            vld_d[k]  = vld_q[k-1];
            opa_d[k]  = rot_in(opa_q[k-1], opa_q[k-1][CHUNK-1:0]);
            opb_d[k]  = rot_in(opb_q[k-1], opb_q[k-1][CHUNK-1:0]);
            res_d[k]  = rot_in(res_q[k-1], slice_sum[CHUNK-1:0]);
            cy_d[k]   = slice_sum[CHUNK];
`ifdef PIPE_ADDER_SAT_EN
            sat_d[k]  = sat_q[k-1];
`endif
         end
      end
   end

   // Pipeline registers; reset discards everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         cy_q  <= '0;
`ifdef PIPE_ADDER_SAT_EN
         sat_q <= '0;
`endif
         for (int k = 0; k < RANKS; k++) begin
            opa_q[k] <= '0;
            opb_q[k] <= '0;
            res_q[k] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         cy_q  <= cy_d;
`ifdef PIPE_ADDER_SAT_EN
         sat_q <= sat_d;
`endif
         for (int k = 0; k < RANKS; k++) begin
            opa_q[k] <= opa_d[k];
            opb_q[k] <= opb_d[k];
            res_q[k] <= res_d[k];
         end
      end
   end

   // Output flags derived from the output rank only, so they hold during a stall.
   always_comb begin
      in_ready  = adv;
      out_valid = vld_q[RANKS-1];
      cout      = cy_q[RANKS-1];
      a_msb     = opa_q[RANKS-1][WIDTH-1];
      b_msb     = opb_q[RANKS-1][WIDTH-1];
      ovf       = (a_msb == b_msb) && (res_q[RANKS-1][WIDTH-1] != a_msb);
      sum       = res_q[RANKS-1];
`ifdef PIPE_ADDER_SAT_EN
      // Both operands share a sign on overflow; A's sign picks the rail.
      if (sat_q[RANKS-1] && ovf) begin
         sum = a_msb ? SAT_NEG : SAT_POS;
      end
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_adder
//  Purpose  : Scoreboard bench for pipe_adder (WIDTH=16, CHUNK=4). The
//             driver pushes the expected result of every accepted op; an
//             independent monitor pops and compares whenever an output is
//             transferred. Directed cases first, then a randomised stream
//             with random backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_adder;

   localparam int WIDTH  = 16;
   localparam int CHUNK  = 4;
   localparam int STAGES = WIDTH / CHUNK;
`ifdef PIPE_ADDER_SAT_EN
   localparam bit SAT_ON = 1'b1;
`else
   localparam bit SAT_ON = 1'b0;
`endif

   typedef struct packed {
      logic [WIDTH-1:0] s;
      logic             co;
      logic             ov;
   } exp_t;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a         = '0;
   logic [WIDTH-1:0] b         = '0;
   logic             ci        = 1'b0;
   logic             sub       = 1'b0;
   logic             sat       = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   exp_t sb[$];
   int   checks    = 0;
   int   errors    = 0;
   bit   rnd_ready = 1'b0;

   always #5 clk = ~clk;

   pipe_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .ci       (ci),
      .sub      (sub),
`ifdef PIPE_ADDER_SAT_EN
      .sat      (sat),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf)
   );

   // Reference: whole-word arithmetic straight from the operation definition.
   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic c, input logic is_sub, input logic st);
      logic [WIDTH-1:0] be;
      logic [WIDTH:0]   full;
      exp_t             e;
      be   = is_sub ? ~y : y;
      full = {1'b0, x} + {1'b0, be} + (WIDTH+1)'(is_sub ? 1'b1 : c);
      e.s  = full[WIDTH-1:0];
      e.co = full[WIDTH];
      e.ov = (x[WIDTH-1] == be[WIDTH-1]) && (e.s[WIDTH-1] != x[WIDTH-1]);
      if (st && e.ov)
         e.s = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Present one op from a negedge; returns at the negedge after acceptance.
   task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic c, input logic is_sub, input logic st, output int waited);
      a = x; b = y; ci = c; sub = is_sub; sat = st; in_valid = 1'b1;
      waited = 0;
      #2;
      while (!in_ready && waited < 200) begin
         @(negedge clk); #2;
         waited++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", waited);
      end else begin
         sb.push_back(model(x, y, c, is_sub, sat && SAT_ON));
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 32'(sb.size()), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   // Single op with out_ready=1: out_valid must rise exactly STAGES edges after acceptance.
   task automatic lat_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      int w;
      send(x, y, 1'b0, 1'b0, 1'b0, w);
      in_valid = 1'b0;
      #3;
      chk("lat_edge0", 32'(out_valid), 32'd0);
      for (int j = 1; j <= STAGES; j++) begin
         @(negedge clk); #3;
         chk($sformatf("lat_edge%0d", j), 32'(out_valid), 32'(j == STAGES));
      end
      @(negedge clk);
   endtask

   // Monitor: handshake rule, stall stability, and scoreboard pop on transfer.
   initial begin : monitor
      bit               held_v;
      logic [WIDTH+1:0] held;
      exp_t             e;
      held_v = 1'b0;
      held   = '0;
      forever begin
         @(negedge clk); #2;
         chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
         if (out_valid && !out_ready) begin
            if (held_v) chk("stall_hold", 32'({sum, cout, ovf}), 32'(held));
            held   = {sum, cout, ovf};
            held_v = 1'b1;
         end else begin
            held_v = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_output: sum=0x%0h with no op outstanding", sum);
            end else begin
               e = sb.pop_front();
               chk("result{sum,cout,ovf}", 32'({sum, cout, ovf}), 32'(e));
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL global_timeout: bench did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin : main
      int w;
      int tot;
      int lat_w;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum",       32'(sum),       32'd0);
      chk("rst_cout",      32'(cout),      32'd0);
      chk("rst_ovf",       32'(ovf),       32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic add with exact latency
      lat_op(16'h1234, 16'h4321);

      // Carry chain, overflow, saturation, subtract
      send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, w);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, w);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, w);
      send(16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1, w);
      send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, w);
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, w);
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, w);
      drain();

      // Back-to-back stream: 8 accepted without wait, 8 consecutive outputs
      tot = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               send(16'(i), 16'(i * 256), 1'b0, 1'b0, 1'b0, w);
               tot += w;
            end
            idle(0);
         end
         begin
            int cnt = 0, run = 0, best = 0;
            repeat (20) begin
               @(negedge clk); #3;
               if (out_valid) begin
                  cnt++; run++;
                  if (run > best) best = run;
               end else begin
                  run = 0;
               end
            end
            chk("stream_out_count", 32'(cnt), 32'd8);
            chk("stream_out_run",   32'(best), 32'd8);
         end
      join
      chk("stream_in_waits", 32'(tot), 32'd0);
      drain();

      // Backpressure: 6 ops, out_ready low for 5 cycles mid-stream
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(16'(1000 * i + 7), 16'(i * 16'h1111), 1'(i), 1'(i >> 1), 1'b0, w);
            idle(0);
         end
         begin
            repeat (5) @(negedge clk);
            out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               #3;
               chk("stall_in_ready",  32'(in_ready),  32'd0);
               chk("stall_out_valid", 32'(out_valid), 32'd1);
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset mid-flight: in-flight ops vanish, nothing emitted afterwards
      for (int i = 0; i < 3; i++)
         send(16'(16'h0F0F + i), 16'h0101, 1'b0, 1'b0, 1'b0, w);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      sb.delete();
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_sum",       32'(sum),       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #3;
         chk("post_rst_idle", 32'(out_valid), 32'd0);
         @(negedge clk);
      end
      lat_op(16'hA5A5, 16'h1111);
      drain();

      // Randomised stream with random gaps and random backpressure
      rnd_ready = 1'b1;
      fork
         begin
            while (rnd_ready) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(negedge clk);
            end
         end
      join_none
      lat_w = 0;
      for (int i = 0; i < 300; i++) begin
         send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), w);
         lat_w += w;
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(0);
      rnd_ready = 1'b0;
      @(negedge clk);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
